// File: rtl/tagged_uart_pkg.sv
// tagged_uart_pkg: FSM states, error codes and default command tag for tagged_word_uart_rx
// Macro: TAGGED_WORD_UART_RX_CHECKSUM_EN adds the checksum states and code.
package tagged_uart_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        WAIT_TAG = 3'd2,
        GET_CMD  = 3'd3
`ifdef TAGGED_WORD_UART_RX_CHECKSUM_EN
        ,
        GET_CSUM_TAG = 3'd4,
        GET_CSUM     = 3'd5
`endif
    } state_t;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TAG     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
`ifdef TAGGED_WORD_UART_RX_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM    = 2'd3;
`endif
    localparam logic [7:0] DEFAULT_CMD_TAG = 8'd0;
endpackage

// File: rtl/rx_timeout_counter.sv
// rx_timeout_counter: inter-byte watchdog
// Ports: clk, reset (sync, active-high), run (count enable), clear (restart),
//        expired (high in the cycle the count reaches TIMEOUT_CYC-1 without clear)
module rx_timeout_counter #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] timer;
    always_ff @(posedge clk)
        timer <= (reset || clear || !run) ? '0 : timer + 1'b1;
    // a byte in the expiry cycle suppresses the timeout
    assign expired = run && !clear && timer == TW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/tagged_word_uart_rx.sv
// tagged_word_uart_rx: assembles tagged UART bytes into little-endian words and command bytes
// Ports: clk, reset (sync, active-high), byte_data/byte_valid (from uart_sm_rx),
//        word_data/word_valid, cmd_data/cmd_valid, err/err_code, busy
// Macro: TAGGED_WORD_UART_RX_CHECKSUM_EN appends an XOR checksum (tag NBYTES+1) to each word.
module tagged_word_uart_rx
    import tagged_uart_pkg::*;
#(
    parameter int         NBYTES      = 4,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] CMD_TAG     = DEFAULT_CMD_TAG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    output logic [8*NBYTES-1:0] word_data,
    output logic                word_valid,
    output logic [7:0]          cmd_data,
    output logic                cmd_valid,
    output logic                err,
    output logic [1:0]          err_code,
    output logic                busy
);
    localparam int DW = 8 * NBYTES;
    state_t        state;
    logic [3:0]    k;
    logic [DW-1:0] buffer, merged;
    logic          expired;
`ifdef TAGGED_WORD_UART_RX_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    rx_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .run     (busy),
        .clear   (byte_valid),
        .expired (expired)
    );

    // buffer with the incoming byte dropped into slot k; stale slots are kept
    always_comb begin
        merged = buffer;
        for (int i = 0; i < NBYTES; i++)
            if (k == 4'(i + 1)) merged[8*i +: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= 4'd1;
            buffer     <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            cmd_data   <= '0;
            cmd_valid  <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            busy       <= 1'b0;
`ifdef TAGGED_WORD_UART_RX_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            word_valid <= 1'b0;
            cmd_valid  <= 1'b0;
            err        <= 1'b0;
            if (byte_valid) begin
                case (state)
                    IDLE: begin
                        if (byte_data == 8'd1) begin
                            state <= GET_DATA;
                            k     <= 4'd1;
                            busy  <= 1'b1;
                        end else if (byte_data == CMD_TAG) begin
                            state <= GET_CMD;
                            busy  <= 1'b1;
                        end
                    end
                    GET_DATA: begin
                        buffer <= merged;
`ifdef TAGGED_WORD_UART_RX_CHECKSUM_EN
                        csum   <= (k == 4'd1) ? byte_data : csum ^ byte_data;
`endif
                        if (k == 4'(NBYTES)) begin
`ifdef TAGGED_WORD_UART_RX_CHECKSUM_EN
                            state <= GET_CSUM_TAG;
`else
                            state      <= IDLE;
                            busy       <= 1'b0;
                            word_data  <= merged;
                            word_valid <= 1'b1;
`endif
                        end else begin
                            k     <= k + 4'd1;
                            state <= WAIT_TAG;
                        end
                    end
                    WAIT_TAG: begin
                        if (byte_data == {4'd0, k}) begin
                            state <= GET_DATA;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_TAG;
                            // a fresh tag 1 restarts the frame instead of dropping it
                            if (byte_data == 8'd1) begin
                                k     <= 4'd1;
                                state <= GET_DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    GET_CMD: begin
                        cmd_data  <= byte_data;
                        cmd_valid <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
`ifdef TAGGED_WORD_UART_RX_CHECKSUM_EN
                    GET_CSUM_TAG: begin
                        if (byte_data == 8'(NBYTES + 1)) begin
                            state <= GET_CSUM;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_TAG;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end
                    end
                    GET_CSUM: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (byte_data == csum) begin
                            word_data  <= buffer;
                            word_valid <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end
`endif
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (expired) begin
                state    <= IDLE;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end
        end
    end
endmodule

// File: tb/tb_tagged_word_uart_rx.sv
// tb_tagged_word_uart_rx: directed and random byte streams checked against a frame-level model
module tb_tagged_word_uart_rx;
    localparam int NB = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_valid = 1'b0;
    logic [31:0] word_data;
    logic        word_valid;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    tagged_word_uart_rx #(.NBYTES(NB), .TIMEOUT_CYC(TO), .CMD_TAG(8'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .word_data  (word_data),
        .word_valid (word_valid),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: mode 0 idle, 1 expecting data byte at pos, 2 expecting tag pos, 3 expecting command
    int          mode = 0;
    int          pos = 1;
    int          gap = 0;
    logic [7:0]  slot [NB];
    logic [31:0] exp_word = '0;
    logic [7:0]  exp_cmd = '0;
    logic [1:0]  exp_code = '0;
    logic        ev_w = 1'b0, ev_c = 1'b0, ev_e = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("word_valid", 64'(word_valid), 64'(ev_w));
        chk("word_data", 64'(word_data), 64'(exp_word));
        chk("cmd_valid", 64'(cmd_valid), 64'(ev_c));
        chk("cmd_data", 64'(cmd_data), 64'(exp_cmd));
        chk("err", 64'(err), 64'(ev_e));
        chk("err_code", 64'(err_code), 64'(exp_code));
        chk("busy", 64'(busy), 64'(mode != 0));
    endtask

    task automatic model_byte(input logic [7:0] b);
        ev_w = 0; ev_c = 0; ev_e = 0; gap = 0;
        case (mode)
            0: if (b == 8'd1) begin mode = 1; pos = 1; end
               else if (b == 8'd0) mode = 3;
            1: begin
                slot[pos-1] = b;
                if (pos == NB) begin
                    for (int i = 0; i < NB; i++) exp_word[8*i +: 8] = slot[i];
                    ev_w = 1; mode = 0;
                end else begin
                    pos++; mode = 2;
                end
            end
            2: if (int'(b) == pos) mode = 1;
               else begin
                   ev_e = 1; exp_code = 2'd1;
                   if (b == 8'd1) begin pos = 1; mode = 1; end else mode = 0;
               end
            default: begin exp_cmd = b; ev_c = 1; mode = 0; end
        endcase
    endtask

    task automatic put(input logic [7:0] b);
        byte_data = b;
        byte_valid = 1'b1;
        model_byte(b);
        @(posedge clk);
        #1 byte_valid = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ev_w = 0; ev_c = 0; ev_e = 0;
            if (mode != 0) begin
                gap++;
                if (gap == TO) begin mode = 0; ev_e = 1; exp_code = 2'd2; end
            end
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        byte_data = 8'd1;
        byte_valid = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        byte_valid = 1'b0;
        mode = 0; pos = 1; gap = 0;
        exp_word = '0; exp_cmd = '0; exp_code = '0;
        ev_w = 0; ev_c = 0; ev_e = 0;
        for (int i = 0; i < NB; i++) slot[i] = '0;
        @(negedge clk);
        check_all();
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < NB; i++) begin
            put(8'(i + 1));
            idle($urandom_range(0, max_gap));
            put(w[8*i +: 8]);
            if (i < NB - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        for (int i = 0; i < NB; i++) slot[i] = '0;
        @(negedge clk);
        do_reset();
        send_word(32'hDEADBEEF, 0);
        chk("deadbeef", 64'(word_data), 64'h0000_0000_DEAD_BEEF);
        idle(1);
        put(8'h00); put(8'h5A);
        chk("cmd5a", 64'(cmd_data), 64'h5A);
        put(8'h01); put(8'h11); put(8'h07);
        chk("badtag_code", 64'(err_code), 64'd1);
        send_word(32'hDDCCBBAA, 0);
        chk("ddccbbaa", 64'(word_data), 64'h0000_0000_DDCC_BBAA);
        put(8'h01); put(8'h11); idle(TO);
        chk("timeout_code", 64'(err_code), 64'd2);
        put(8'h01); put(8'h22); idle(TO - 1); put(8'h02);
        chk("byte_at_expiry_busy", 64'(busy), 64'd1);
        put(8'h33); put(8'h03); put(8'h44); put(8'h04); put(8'h55);
        put(8'h01); put(8'h66); put(8'h01); put(8'h77);
        put(8'h01); put(8'h11); put(8'h02);
        do_reset();
        send_word(32'h12345678, 1);
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: send_word($urandom, 2);
                3: begin put(8'h00); put(8'($urandom)); end
                4: repeat (3) put(8'($urandom_range(0, 5)));
                5: idle($urandom_range(1, TO + 1));
                6: put(8'($urandom));
                default: begin put(8'h01); put(8'($urandom)); idle($urandom_range(TO - 2, TO)); end
            endcase
        end
        idle(TO);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
